// File: rtl/des_key_schedule.sv
// Sequential DES key-schedule stage: turns the PC-1 output into sixteen rotated C||D words, one per handshake.
// Optional decrypt schedule (right rotations) is built only when DES_KEY_SCHED_DECRYPT_EN is defined.
module des_key_schedule #(
    parameter int ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [56:1] key_in,
    input  logic        decrypt,
    input  logic        key_ready,
    output logic        key_valid,
    output logic [56:1] cd_out,
    output logic [3:0]  round,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    logic [1:0]  state_q, state_d;
    logic [56:1] cd_q, cd_d;
    logic [3:0]  round_q, round_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  next_round;
    logic        shift_two;

    // Rotate each 28-bit half independently by one or two places.
    function automatic logic [56:1] rot_left(input logic [56:1] cd, input logic two);
        logic [28:1] c;
        logic [28:1] d;
        c = cd[56:29];
        d = cd[28:1];
        if (two) begin
            c = {c[26:1], c[28:27]};
            d = {d[26:1], d[28:27]};
        end else begin
            c = {c[27:1], c[28]};
            d = {d[27:1], d[28]};
        end
        return {c, d};
    endfunction

`ifdef DES_KEY_SCHED_DECRYPT_EN
    function automatic logic [56:1] rot_right(input logic [56:1] cd, input logic two);
        logic [28:1] c;
        logic [28:1] d;
        c = cd[56:29];
        d = cd[28:1];
        if (two) begin
            c = {c[2:1], c[28:3]};
            d = {d[2:1], d[28:3]};
        end else begin
            c = {c[1], c[28:2]};
            d = {d[1], d[28:2]};
        end
        return {c, d};
    endfunction

    logic mode_q, mode_d;
`else
    logic unused_decrypt;
    assign unused_decrypt = decrypt;
`endif

    // Past round 0 both schedules shift by 1 at rounds 1, 8 and 15 and by 2 elsewhere;
    // only the direction differs between encrypt and decrypt.
    assign next_round = round_q + 4'd1;
    assign shift_two  = !((next_round == 4'd1) || (next_round == 4'd8) || (next_round == 4'd15));

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        round_d = round_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef DES_KEY_SCHED_DECRYPT_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d = S_RUN;
                    round_d = 4'd0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
`ifdef DES_KEY_SCHED_DECRYPT_EN
                    mode_d  = decrypt;
                    cd_d    = decrypt ? key_in : rot_left(key_in, 1'b0);
`else
                    cd_d    = rot_left(key_in, 1'b0);
`endif
                end
            end
            S_RUN: begin
                if (valid_q && key_ready) begin
                    if (round_q == LAST_ROUND) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        round_d = next_round;
`ifdef DES_KEY_SCHED_DECRYPT_EN
                        cd_d    = mode_q ? rot_right(cd_q, shift_two) : rot_left(cd_q, shift_two);
`else
                        cd_d    = rot_left(cd_q, shift_two);
`endif
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cd_q    <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            round_q <= round_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef DES_KEY_SCHED_DECRYPT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
        end
    end
`endif

    assign key_valid = valid_q;
    assign cd_out    = cd_q;
    assign round     = round_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: encrypt sequence, C wrap, decrypt (or ignored decrypt), backpressure, reset abort.
module tb_des_key_schedule;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [56:1] key_in;
    logic        decrypt;
    logic        key_ready;
    logic        key_valid;
    logic [56:1] cd_out;
    logic [3:0]  round;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    // Encrypt words for key_in = 1: D = 1 rotated left by the cumulative shift.
    logic [55:0] enc_one [16] = '{
        56'h2,      56'h4,      56'h10,      56'h40,
        56'h100,    56'h400,    56'h1000,    56'h4000,
        56'h8000,   56'h20000,  56'h80000,   56'h200000,
        56'h800000, 56'h2000000, 56'h8000000, 56'h1
    };

    des_key_schedule #(.ROUNDS(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .key_in    (key_in),
        .decrypt   (decrypt),
        .key_ready (key_ready),
        .key_valid (key_valid),
        .cd_out    (cd_out),
        .round     (round),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge in IDLE; returns at the negedge showing round 0.
    task automatic start(input logic [56:1] k, input logic dec);
        load      = 1'b1;
        key_in    = k;
        decrypt   = dec;
        key_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load    = 1'b0;
        decrypt = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, {63'd0, seen}, 64'd1);
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        load      = 1'b0;
        key_in    = '0;
        decrypt   = 1'b0;
        key_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cd",    64'(cd_out), 64'd0);
        check("rst_valid", 64'(key_valid), 64'd0);
        check("rst_round", 64'(round), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        // Encrypt key 1, full sequence, with a stray load at round 7.
        start(56'h1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("enc_word%0d", k), 64'(cd_out), 64'(enc_one[k]));
            check($sformatf("enc_round%0d", k), 64'(round), 64'(k));
            check($sformatf("enc_valid%0d", k), 64'(key_valid), 64'd1);
            if (k == 7) begin
                load   = 1'b1;
                key_in = 56'hABCDEF12345678;
            end
            if (k == 8) load = 1'b0;
        end
        @(negedge clk);
        check("enc_done",       64'(done), 64'd1);
        check("enc_done_valid", 64'(key_valid), 64'd0);
        check("enc_done_busy",  64'(busy), 64'd1);
        check("enc_done_cd",    64'(cd_out), 64'h1);
        load   = 1'b1;
        key_in = 56'h55;
        @(negedge clk);
        check("enc_idle_busy", 64'(busy), 64'd0);
        check("enc_idle_done", 64'(done), 64'd0);
        load = 1'b0;
        @(negedge clk);
        check("load_in_done_ignored", 64'(busy), 64'd0);

        // C-half wrap: bit 56 rotates into bit 29.
        start(56'h80000000000000, 1'b0);
        check("cwrap_word0", 64'(cd_out), 64'h00000010000000);
        wait_done("cwrap_done_timeout");

`ifdef DES_KEY_SCHED_DECRYPT_EN
        start(56'h1, 1'b1);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 0)  check("dec_word0",  64'(cd_out), 64'h1);
            if (k == 1)  check("dec_word1",  64'(cd_out), 64'h8000000);
            if (k == 15) check("dec_word15", 64'(cd_out), 64'h2);
        end
        @(negedge clk);
        check("dec_done", 64'(done), 64'd1);
        @(negedge clk);
`else
        start(56'h1, 1'b1);
        check("dec_ignored_word0", 64'(cd_out), 64'h2);
        wait_done("dec_ignored_done_timeout");
`endif

        // Backpressure at round 4.
        start(56'h1, 1'b0);
        repeat (4) @(negedge clk);
        check("bp_word4", 64'(cd_out), 64'h100);
        key_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold_cd%0d", i), 64'(cd_out), 64'h100);
            check($sformatf("bp_hold_round%0d", i), 64'(round), 64'd4);
            check($sformatf("bp_hold_valid%0d", i), 64'(key_valid), 64'd1);
        end
        key_ready = 1'b1;
        @(negedge clk);
        check("bp_word5",  64'(cd_out), 64'h400);
        check("bp_round5", 64'(round), 64'd5);
        wait_done("bp_done_timeout");

        // Asynchronous reset at round 9.
        start(56'h1, 1'b0);
        repeat (9) @(negedge clk);
        check("rr_round9", 64'(round), 64'd9);
        #2 rst_n = 1'b0;
        #1;
        check("rr_cd",    64'(cd_out), 64'd0);
        check("rr_valid", 64'(key_valid), 64'd0);
        check("rr_round", 64'(round), 64'd0);
        check("rr_busy",  64'(busy), 64'd0);
        check("rr_done",  64'(done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        check("rr_hold_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        start(56'h1, 1'b0);
        check("rr_restart_word0", 64'(cd_out), 64'h2);
        check("rr_restart_round", 64'(round), 64'd0);
        wait_done("rr_done_timeout");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
